// File: rtl/sbox_pipe_array.sv
// Pipelined multi-lane AES combined S-box / inverse S-box with valid/ready flow control.
// Per lane: x^-1 = x^16 * (x^17)^-1, where D = x^17 lies in the GF(2^4) subfield.
module sbox_pipe_array #(
    parameter int NUM_LANES   = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_encrypt,
    input  logic [8*NUM_LANES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_encrypt,
    output logic [8*NUM_LANES-1:0] out_data,
    output logic                   busy
);
    localparam int W = 8 * NUM_LANES;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    // Input transform and exponentiation: returns {x^16, D}.
    function automatic logic [15:0] lane_exp(input logic [7:0] b, input logic enc);
        logic [7:0] x;
        logic [7:0] x16;
        x   = enc ? b : inv_affine(b);
        x16 = x;
        for (int i = 0; i < 4; i++) x16 = gf_mul(x16, x16);
        return {x16, gf_mul(x16, x)};
    endfunction

    // D^14 is D^-1 inside GF(2^4) and maps 0 to 0.
    function automatic logic [7:0] sub_inv(input logic [7:0] d);
        logic [7:0] d2;
        logic [7:0] d4;
        logic [7:0] d8;
        d2 = gf_mul(d, d);
        d4 = gf_mul(d2, d2);
        d8 = gf_mul(d4, d4);
        return gf_mul(gf_mul(d8, d4), d2);
    endfunction

    function automatic logic [7:0] lane_out(input logic [7:0] x16, input logic [7:0] e, input logic enc);
        logic [7:0] m;
        m = gf_mul(x16, e);
        return enc ? fwd_affine(m) : m;
    endfunction

    logic [PIPE_STAGES-1:0] r_valid;
    logic [PIPE_STAGES-1:0] w_en;
    logic [PIPE_STAGES:0]   w_vchain;
    logic [W-1:0]           w_x16;
    logic [W-1:0]           w_d;
    logic [W-1:0]           w_out_next;
    logic                   w_out_enc_next;
    logic [W-1:0]           r_out_data;
    logic                   r_out_enc;

    // Stage k loads when it is empty or everything after it can move; in_ready is stage 0's load.
    always_comb begin
        logic w_acc;
        w_acc = out_ready;
        w_en  = '0;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            w_acc   = w_acc | ~r_valid[k];
            w_en[k] = w_acc;
        end
    end

    assign w_vchain = {r_valid, in_valid};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++)
                if (w_en[k]) r_valid[k] <= w_vchain[k];
        end
    end

    always_comb begin
        w_x16 = '0;
        w_d   = '0;
        for (int l = 0; l < NUM_LANES; l++)
            {w_x16[8*l +: 8], w_d[8*l +: 8]} = lane_exp(in_data[8*l +: 8], in_encrypt);
    end

    if (PIPE_STAGES == 1) begin : g_p1
        always_comb begin
            w_out_next = '0;
            for (int l = 0; l < NUM_LANES; l++)
                w_out_next[8*l +: 8] = lane_out(w_x16[8*l +: 8], sub_inv(w_d[8*l +: 8]), in_encrypt);
            w_out_enc_next = in_encrypt;
        end
    end else begin : g_pn
        logic [W-1:0] r_s1_x16;
        logic [W-1:0] r_s1_d;
        logic         r_s1_enc;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s1_x16 <= '0;
                r_s1_d   <= '0;
                r_s1_enc <= 1'b0;
            end else if (w_en[0]) begin
                r_s1_x16 <= w_x16;
                r_s1_d   <= w_d;
                r_s1_enc <= in_encrypt;
            end
        end

        if (PIPE_STAGES == 2) begin : g_p2
            always_comb begin
                w_out_next = '0;
                for (int l = 0; l < NUM_LANES; l++)
                    w_out_next[8*l +: 8] = lane_out(r_s1_x16[8*l +: 8], sub_inv(r_s1_d[8*l +: 8]), r_s1_enc);
                w_out_enc_next = r_s1_enc;
            end
        end else begin : g_p3
            logic [W-1:0] w_s1_e;
            logic [W-1:0] r_s2_x16;
            logic [W-1:0] r_s2_e;
            logic         r_s2_enc;

            always_comb begin
                w_s1_e = '0;
                for (int l = 0; l < NUM_LANES; l++)
                    w_s1_e[8*l +: 8] = sub_inv(r_s1_d[8*l +: 8]);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_s2_x16 <= '0;
                    r_s2_e   <= '0;
                    r_s2_enc <= 1'b0;
                end else if (w_en[1]) begin
                    r_s2_x16 <= r_s1_x16;
                    r_s2_e   <= w_s1_e;
                    r_s2_enc <= r_s1_enc;
                end
            end

            always_comb begin
                w_out_next = '0;
                for (int l = 0; l < NUM_LANES; l++)
                    w_out_next[8*l +: 8] = lane_out(r_s2_x16[8*l +: 8], r_s2_e[8*l +: 8], r_s2_enc);
                w_out_enc_next = r_s2_enc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data <= '0;
            r_out_enc  <= 1'b0;
        end else if (w_en[PIPE_STAGES-1]) begin
            r_out_data <= w_out_next;
            r_out_enc  <= w_out_enc_next;
        end
    end

    assign in_ready    = w_en[0];
    assign out_valid   = r_valid[PIPE_STAGES-1];
    assign out_data    = r_out_data;
    assign out_encrypt = r_out_enc;
    assign busy        = |r_valid;
endmodule
